// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, fetches over a variable-latency req/ready handshake,
// holds the fetched word across stalls and discards in-flight fetches on redirect.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic        if_enable,
    output logic        if_flush,
    output logic [31:0] IF_PC_Plus4,
    output logic [31:0] IF_Instruction
);

    typedef enum logic [1:0] {
        StFetch,
        StHold,
        StDiscard
    } state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] req_addr_q;
    logic [31:0] hold_instr_q;
    logic [31:0] hold_pc4_q;

    logic [31:0] target;
    logic [31:0] req_pc4;

    assign target  = {redirect_target[31:2], 2'b00};
    assign req_pc4 = req_addr_q + 32'd4;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StFetch;
            pc_q         <= RESET_PC;
            req_addr_q   <= RESET_PC;
            hold_instr_q <= 32'h0;
            hold_pc4_q   <= 32'h0;
        end else begin
            unique case (state_q)
                StFetch: begin
                    if (imem_ready) begin
                        if (redirect) begin
                            req_addr_q <= target;
                        end else if (stall) begin
                            hold_instr_q <= imem_rdata;
                            hold_pc4_q   <= req_pc4;
                            state_q      <= StHold;
                        end else begin
                            req_addr_q <= req_pc4;
                        end
                    end else if (redirect) begin
                        // Request already on the bus must complete before the target can go out.
                        pc_q    <= target;
                        state_q <= StDiscard;
                    end
                end
                StHold: begin
                    if (redirect) begin
                        req_addr_q <= target;
                        state_q    <= StFetch;
                    end else if (!stall) begin
                        req_addr_q <= hold_pc4_q;
                        state_q    <= StFetch;
                    end
                end
                StDiscard: begin
                    if (redirect) begin
                        pc_q <= target;
                    end
                    if (imem_ready) begin
                        req_addr_q <= redirect ? target : pc_q;
                        state_q    <= StFetch;
                    end
                end
                default: state_q <= StFetch;
            endcase
        end
    end

    always_comb begin
        imem_req       = 1'b0;
        imem_addr      = 32'h0;
        if_valid       = 1'b0;
        if_enable      = 1'b0;
        if_flush       = 1'b0;
        IF_PC_Plus4    = 32'h0;
        IF_Instruction = 32'h0;
        if (!reset) begin
            if_flush  = redirect;
            imem_req  = (state_q != StHold);
            imem_addr = req_addr_q;
            unique case (state_q)
                StFetch: begin
                    if (imem_ready && !redirect) begin
                        if_valid       = 1'b1;
                        IF_Instruction = imem_rdata;
                        IF_PC_Plus4    = req_pc4;
                    end
                end
                StHold: begin
                    if (!redirect) begin
                        if_valid       = 1'b1;
                        IF_Instruction = hold_instr_q;
                        IF_PC_Plus4    = hold_pc4_q;
                    end
                end
                default: ;
            endcase
            if_enable = if_valid & ~stall & ~redirect;
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios followed by random traffic, all checked
// against a word-level reference model of the fetch/hold/discard rules.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic        if_enable;
    logic        if_flush;
    logic [31:0] IF_PC_Plus4;
    logic [31:0] IF_Instruction;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    logic [31:0] m_addr;       // address currently being requested
    bit          m_have;       // a word is parked waiting for stall to drop
    logic [31:0] m_h_instr;
    logic [31:0] m_h_pc4;
    bit          m_discard;    // an abandoned request is still outstanding
    logic [31:0] m_pending;    // where to go once the abandoned request completes

    if_fetch_stage dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ready      (imem_ready),
        .imem_rdata      (imem_rdata),
        .if_valid        (if_valid),
        .if_enable       (if_enable),
        .if_flush        (if_flush),
        .IF_PC_Plus4     (IF_PC_Plus4),
        .IF_Instruction  (IF_Instruction)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, compare every output against the model, then advance the model.
    task automatic step(input bit r, input bit st, input bit rd, input logic [31:0] tgt,
                        input bit rdy, input logic [31:0] data);
        logic [31:0] al_tgt;
        bit          e_req, e_valid;
        logic [31:0] e_addr, e_instr, e_pc4;
        @(negedge clk);
        reset           = r;
        stall           = st;
        redirect        = rd;
        redirect_target = tgt;
        imem_ready      = rdy;
        imem_rdata      = data;
        #1;
        al_tgt = tgt & 32'hFFFF_FFFC;
        if (r) begin
            e_req = 0; e_addr = 0; e_valid = 0; e_instr = 0; e_pc4 = 0;
        end else begin
            e_req   = !m_have;
            e_addr  = m_addr;
            e_valid = !rd && (m_have || (!m_discard && rdy));
            e_instr = !e_valid ? 32'h0 : (m_have ? m_h_instr : data);
            e_pc4   = !e_valid ? 32'h0 : (m_have ? m_h_pc4 : m_addr + 32'd4);
        end
        check("imem_req", {31'h0, imem_req}, {31'h0, e_req});
        check("imem_addr", imem_addr, e_addr);
        check("if_valid", {31'h0, if_valid}, {31'h0, e_valid});
        check("if_enable", {31'h0, if_enable}, {31'h0, e_valid && !st});
        check("if_flush", {31'h0, if_flush}, {31'h0, rd && !r});
        check("IF_Instruction", IF_Instruction, e_instr);
        check("IF_PC_Plus4", IF_PC_Plus4, e_pc4);

        if (r) begin
            m_addr = 32'h0; m_have = 0; m_discard = 0; m_h_instr = 0; m_h_pc4 = 0;
            m_pending = 32'h0;
        end else if (m_have) begin
            if (rd) begin
                m_addr = al_tgt; m_have = 0;
            end else if (!st) begin
                m_addr = m_h_pc4; m_have = 0;
            end
        end else if (m_discard) begin
            if (rd) m_pending = al_tgt;
            if (rdy) begin
                m_addr = m_pending; m_discard = 0;
            end
        end else if (rdy) begin
            if (rd) m_addr = al_tgt;
            else if (st) begin
                m_have = 1; m_h_instr = data; m_h_pc4 = m_addr + 32'd4;
            end else m_addr = m_addr + 32'd4;
        end else if (rd) begin
            m_discard = 1; m_pending = al_tgt;
        end
    endtask

    initial begin
        logic [31:0] tgt;
        m_addr = 0; m_have = 0; m_discard = 0; m_h_instr = 0; m_h_pc4 = 0; m_pending = 0;
        reset = 1; stall = 0; redirect = 0; redirect_target = 0; imem_ready = 0; imem_rdata = 0;

        // Reset, then back-to-back fetches with ready tied high
        step(1, 0, 0, 0, 1, 32'hDEAD_BEEF);
        step(0, 0, 0, 0, 1, 32'h1111_0000);
        check("t1_addr0", imem_addr, 32'h0);
        check("t1_pc4_0", IF_PC_Plus4, 32'h4);
        step(0, 0, 0, 0, 1, 32'h1111_0004);
        check("t1_addr4", imem_addr, 32'h4);
        step(0, 0, 0, 0, 1, 32'h1111_0008);
        check("t1_pc4_12", IF_PC_Plus4, 32'hC);
        step(0, 0, 0, 0, 1, 32'h1111_000C);

        // Memory wait states on 0x10
        repeat (3) step(0, 0, 0, 0, 0, 32'hBAD0_BAD0);
        check("t2_addr_held", imem_addr, 32'h10);
        step(0, 0, 0, 0, 1, 32'h8C22_0004);
        check("t2_instr", IF_Instruction, 32'h8C22_0004);
        check("t2_pc4", IF_PC_Plus4, 32'h14);

        // Stall when the word at 0x20 arrives
        repeat (3) step(0, 0, 0, 0, 1, $urandom);
        step(0, 1, 0, 0, 1, 32'h2020_2020);
        step(0, 1, 0, 0, 1, 32'hBAD1_BAD1);
        check("t3_hold_req", {31'h0, imem_req}, 32'h0);
        step(0, 0, 0, 0, 1, 32'hBAD2_BAD2);
        check("t3_accept", IF_Instruction, 32'h2020_2020);
        step(0, 0, 0, 0, 1, $urandom);
        check("t3_next", imem_addr, 32'h24);

        // Redirect while 0x40 is outstanding
        repeat (6) step(0, 0, 0, 0, 1, $urandom);
        step(0, 0, 1, 32'h100, 0, 32'hBAD3_BAD3);
        step(0, 0, 0, 0, 0, 32'hBAD4_BAD4);
        check("t4_addr_held", imem_addr, 32'h40);
        step(0, 0, 0, 0, 1, 32'hBAD5_BAD5);
        step(0, 0, 0, 0, 0, 32'h0);
        check("t4_target", imem_addr, 32'h100);

        // Redirect and stall together while holding
        step(0, 1, 0, 0, 1, 32'h3030_3030);
        step(0, 1, 1, 32'h203, 1, 32'h0);
        step(0, 0, 0, 0, 0, 32'h0);
        check("t5_target", imem_addr, 32'h200);

        // Two redirects during discard (latest wins), then reset in discard
        step(0, 0, 1, 32'h300, 0, 32'h0);
        step(0, 0, 1, 32'h400, 0, 32'h0);
        step(0, 0, 0, 0, 1, 32'hBAD6_BAD6);
        step(0, 0, 0, 0, 0, 32'h0);
        check("latest_wins", imem_addr, 32'h400);
        step(0, 0, 1, 32'h500, 0, 32'h0);
        step(1, 0, 0, 0, 1, 32'hBAD7_BAD7);
        step(0, 0, 0, 0, 1, 32'h4444_4444);
        check("t6_reset_pc", imem_addr, 32'h0);

        // Address wrap
        step(0, 0, 1, 32'hFFFF_FFFE, 1, 32'h0);
        step(0, 0, 0, 0, 1, 32'h5555_5555);
        check("wrap_pc4", IF_PC_Plus4, 32'h0);
        step(0, 0, 0, 0, 1, 32'h6666_6666);
        check("wrap_addr", imem_addr, 32'h0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
            step($urandom_range(0, 63) == 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 7) == 0, tgt, $urandom_range(0, 1) == 1, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
